cheat_code_loader: RTL and testbench

//  Upstream feeder for the cheat engine: takes the HPS ioctl byte stream of a cheat file,

---
 rtl/cheat_code_loader.sv | 156 +++++++++++++++
 tb/tb_cheat_code_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cheat_code_loader.sv
// cheat_code_loader: assembles 16-byte cheat records from the HPS ioctl
// byte stream into 129-bit engine code words strobed on code[128].
module cheat_code_loader #(
  parameter logic [7:0] CHEAT_INDEX   = 8'd4,
  parameter int         ADDR_W        = 25,
  parameter int         MAX_CODES     = 32,
  parameter int         STROBE_CYCLES = 2,
  localparam int        CNT_W         = $clog2(MAX_CODES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [128:0]      code,
  output logic              engine_reset,
  output logic [CNT_W-1:0]  code_count,
  output logic              error
);

  localparam int SW =
    (STROBE_CYCLES > 2) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST =
    SW'(STROBE_CYCLES - 1);
  localparam logic [SW-1:0] CLR_LAST = SW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_CODES);

  typedef enum logic [2:0] {
    IDLE, CLR, COLLECT, STB_HI, STB_LO
  } state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [127:0]       buf_q, buf_d;
  logic [127:0]       code_q, code_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               act_q;

  logic               active;
  logic               rise;
  logic [3:0]         n;
  logic [6:0]         lo;
  logic [127:0]       wbuf;
  logic               unused_addr;

  assign active = ioctl_download &&
                  (ioctl_index == CHEAT_INDEX);
  assign rise   = active && !act_q;
  assign n      = ioctl_addr[3:0];
  // word w lands at 32*(3-w), byte b at 8*b within it
  assign lo     = {~n[3:2], n[1:0], 3'b000};
  assign unused_addr = ^ioctl_addr[ADDR_W-1:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      code_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      count_q <= count_d;
      err_q   <= err_d;
      act_q   <= active;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    code_d  = code_q;
    count_d = count_q;
    err_d   = err_q;
    wbuf    = buf_q;
    wbuf[lo +: 8] = ioctl_dout;
    if (rise) begin
      state_d = CLR;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CLR: begin
          count_d = '0;
          err_d   = 1'b0;
          buf_d   = '0;
          if (cnt_q == CLR_LAST) begin
            state_d = COLLECT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        COLLECT: begin
          if (!active) begin
            state_d = IDLE;
            buf_d   = '0;
          end else if (ioctl_wr) begin
            buf_d = wbuf;
            if (n == 4'hf) begin
              if (count_q < CNT_MAX) begin
                code_d  = wbuf;
                state_d = STB_HI;
                cnt_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
        STB_HI: begin
          if (ioctl_wr) err_d = 1'b1;
          if (cnt_q == S_LAST) begin
            state_d = STB_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STB_LO: begin
          if (ioctl_wr) err_d = 1'b1;
          if (cnt_q == S_LAST) begin
            cnt_d = '0;
            if (count_q < CNT_MAX)
              count_d = count_q + 1'b1;
            state_d = active ? COLLECT : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    engine_reset = (state_q == CLR);
    ioctl_wait   = (state_q == STB_HI) ||
                   (state_q == STB_LO);
    code         = {state_q == STB_HI, code_q};
    code_count   = count_q;
    error        = err_q;
  end

endmodule

// File: tb/tb_cheat_code_loader.sv
// tb_cheat_code_loader: directed vectors for the cheat record loader,
// hand-computed code words, strobe and back-pressure cycle counts.
module tb_cheat_code_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         ioctl_download;
  logic [7:0]   ioctl_index;
  logic         ioctl_wr;
  logic [24:0]  ioctl_addr;
  logic [7:0]   ioctl_dout;
  logic         ioctl_wait;
  logic [128:0] code;
  logic         engine_reset;
  logic [5:0]   code_count;
  logic         error;

  int nvec = 0;
  int nerr = 0;

  int rst_cyc  = 0;
  int hi_cyc   = 0;
  int wait_cyc = 0;
  int rises    = 0;
  logic prev128 = 1'b0;

  int r0, h0, w0c, e0;

  cheat_code_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .code           (code),
    .engine_reset   (engine_reset),
    .code_count     (code_count),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (engine_reset) rst_cyc <= rst_cyc + 1;
    if (code[128])    hi_cyc  <= hi_cyc + 1;
    if (ioctl_wait)   wait_cyc <= wait_cyc + 1;
    if (code[128] && !prev128) rises <= rises + 1;
    prev128 <= code[128];
  end

  task automatic check(input string tag,
                       input logic [128:0] got,
                       input logic [128:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    r0  = rises;
    h0  = hi_cyc;
    w0c = wait_cyc;
    e0  = rst_cyc;
  endtask

  task automatic send_byte(input logic [3:0] a,
                           input logic [7:0] d);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk);
    #1;
    ioctl_wr   = 1'b0;
  endtask

  // file words are little-endian; rev sends 14..0 then 15
  task automatic send_words(input logic [31:0] a0,
                            input logic [31:0] a1,
                            input logic [31:0] a2,
                            input logic [31:0] a3,
                            input bit rev,
                            input int first,
                            input int cnt);
    logic [31:0] ws [4];
    int a;
    ws[0] = a0; ws[1] = a1;
    ws[2] = a2; ws[3] = a3;
    for (int k = 0; k < cnt; k++) begin
      if (rev) a = (k == 15) ? 15 : 14 - k;
      else     a = first + k;
      send_byte(4'(a), ws[a / 4][8 * (a % 4) +: 8]);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    idle(4);
  endtask

  task automatic stop_dl();
    ioctl_download = 1'b0;
    idle(3);
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    idle(2);
    check("rst_code", code, '0);
    check("rst_wait", 129'(ioctl_wait), 129'd0);
    check("rst_ereset", 129'(engine_reset), 129'd0);
    check("rst_count", 129'(code_count), 129'd0);
    check("rst_err", 129'(error), 129'd0);
    reset = 1'b0;
    idle(2);

    // foreign index: nothing happens
    snap();
    start_dl(8'd0);
    send_words(32'h1, 32'h1234, 32'h0, 32'h63, 0, 0, 16);
    idle(5);
    check("idx0_ereset", 129'(rst_cyc - e0), 129'd0);
    check("idx0_rises", 129'(rises - r0), 129'd0);
    check("idx0_count", 129'(code_count), 129'd0);
    check("idx0_code", code, '0);
    stop_dl();

    // basic record
    snap();
    start_dl(8'd4);
    check("t1_ereset", 129'(rst_cyc - e0), 129'd2);
    send_words(32'h00000001, 32'h00001234,
               32'h00000000, 32'h00000063, 0, 0, 16);
    check("t1_hi_now", 129'(code[128]), 129'd1);
    check("t1_wait_now", 129'(ioctl_wait), 129'd1);
    idle(5);
    check("t1_code", code,
          {1'b0, 128'h00000001_00001234_00000000_00000063});
    check("t1_hi_cyc", 129'(hi_cyc - h0), 129'd2);
    check("t1_wait_cyc", 129'(wait_cyc - w0c), 129'd4);
    check("t1_rises", 129'(rises - r0), 129'd1);
    check("t1_count", 129'(code_count), 129'd1);
    check("t1_err", 129'(error), 129'd0);

    // placement by address, not arrival order
    snap();
    send_words(32'h44332211, 32'h88776655,
               32'hCCBBAA99, 32'h00FFEEDD, 1, 0, 16);
    idle(5);
    check("rev_code", code,
          {1'b0, 128'h44332211_88776655_CCBBAA99_00FFEEDD});
    check("rev_count", 129'(code_count), 129'd2);

    // write during wait is dropped
    snap();
    send_words(32'h000000A5, 32'h00000010,
               32'h00000000, 32'h00000011, 0, 0, 16);
    send_byte(4'd0, 8'hFF);
    idle(5);
    check("t4_err", 129'(error), 129'd1);
    check("t4_code", code,
          {1'b0, 128'h000000A5_00000010_00000000_00000011});
    send_words(32'h00000002, 32'h00000020,
               32'h00000000, 32'h00000022, 0, 1, 15);
    idle(5);
    check("t4_next_code", code,
          {1'b0, 128'h000000A5_00000020_00000000_00000022});
    check("t4_rises", 129'(rises - r0), 129'd2);
    check("t4_count", 129'(code_count), 129'd4);
    stop_dl();

    // capacity limit
    snap();
    start_dl(8'd4);
    check("t3_ereset", 129'(rst_cyc - e0), 129'd2);
    check("t3_count0", 129'(code_count), 129'd0);
    check("t3_err0", 129'(error), 129'd0);
    for (int i = 0; i < 33; i++) begin
      send_words(32'h1, 32'(i), 32'h0, 32'hAA, 0, 0, 16);
      idle(5);
    end
    check("t3_rises", 129'(rises - r0), 129'd32);
    check("t3_count", 129'(code_count), 129'd32);
    check("t3_err", 129'(error), 129'd1);
    check("t3_code", code,
          {1'b0, 128'h00000001_0000001F_00000000_000000AA});
    stop_dl();

    // download ends mid-record
    snap();
    start_dl(8'd4);
    send_words(32'h00000001, 32'h00001234,
               32'h00000000, 32'h00000063, 0, 0, 16);
    idle(5);
    send_words(32'h00000001, 32'h00000099,
               32'h00000000, 32'h00000063, 0, 0, 9);
    stop_dl();
    check("t5_rises", 129'(rises - r0), 129'd1);
    check("t5_count", 129'(code_count), 129'd1);
    check("t5_err", 129'(error), 129'd0);
    check("t5_wait", 129'(ioctl_wait), 129'd0);
    check("t5_code", code,
          {1'b0, 128'h00000001_00001234_00000000_00000063});

    // reset in the middle of a strobe
    start_dl(8'd4);
    send_words(32'h00000001, 32'h00001234,
               32'h00000000, 32'h00000063, 0, 0, 16);
    idle(5);
    send_words(32'h00000003, 32'h00000077,
               32'h00000000, 32'h00000033, 0, 0, 16);
    check("t6_in_hi", 129'(code[128]), 129'd1);
    reset = 1'b1;
    #1;
    check("t6_code", code, '0);
    check("t6_wait", 129'(ioctl_wait), 129'd0);
    check("t6_count", 129'(code_count), 129'd0);
    ioctl_download = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(2);
    snap();
    start_dl(8'd4);
    send_words(32'h00000003, 32'h00000077,
               32'h00000000, 32'h00000033, 0, 0, 16);
    idle(5);
    check("t6_reload", code,
          {1'b0, 128'h00000003_00000077_00000000_00000033});
    check("t6_count1", 129'(code_count), 129'd1);
    check("t6_rises", 129'(rises - r0), 129'd1);
    stop_dl();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
